// File: rtl/heap_memory.sv
`timescale 1ns/1ps
// heap_memory: fixed-capacity array heap for the test-program sequencer.
// Recycles freed arrays through a LIFO free stack before unused ones.
// Ports: clock, reset (sync, active-high); valid/ready request handshake
// carrying action, array, index, in_data; done pulses one cycle and
// qualifies out_data and error, which hold their values otherwise.
module heap_memory #(
   parameter int ARRAYS     = 16,
   parameter int ELEMENTS   = 8,
   parameter int DATA_WIDTH = 12
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        valid,
   input  logic [7:0]                  action,
   input  logic [$clog2(ARRAYS)-1:0]   array,
   input  logic [$clog2(ELEMENTS)-1:0] index,
   input  logic [DATA_WIDTH-1:0]       in_data,
   output logic                        ready,
   output logic                        done,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        error
);
   localparam int AW = $clog2(ARRAYS);
   localparam int IW = $clog2(ELEMENTS);
   localparam int SW = IW + 1;
   localparam int CW = AW + 1;

   localparam logic [7:0] OP_RESET = 8'd1;
   localparam logic [7:0] OP_ALLOC = 8'd2;
   localparam logic [7:0] OP_FREE  = 8'd3;
   localparam logic [7:0] OP_READ  = 8'd4;
   localparam logic [7:0] OP_WRITE = 8'd5;
   localparam logic [7:0] OP_SIZE  = 8'd6;
   localparam logic [7:0] OP_PUSH  = 8'd7;
   localparam logic [7:0] OP_POP   = 8'd8;

   // RESP is the cycle in which done is high; it keeps ready low so a
   // request occupies two cycles.
   typedef enum logic [1:0] {CLEAR, IDLE, EXEC, RESP} state_t;
   state_t state, state_next;

   logic [AW-1:0]         count;
   logic                  clear_req;
   logic [CW-1:0]         allocated;
   logic [CW-1:0]         freed_top;
   logic [AW-1:0]         free_stack [ARRAYS];
   logic [SW-1:0]         sizes      [ARRAYS];
   logic [DATA_WIDTH-1:0] mem        [ARRAYS][ELEMENTS];

   logic [7:0]            op_q;
   logic [AW-1:0]         arr_q;
   logic [IW-1:0]         idx_q;
   logic [DATA_WIDTH-1:0] din_q;

   logic [SW-1:0]         cur_size;
   logic [IW-1:0]         top_idx;
   logic [AW-1:0]         stack_top;
   logic [AW-1:0]         alloc_arr;
   logic                  last_clear;
   logic                  res_err;
   logic [DATA_WIDTH-1:0] res_data;

   assign cur_size   = sizes[arr_q];
   assign top_idx    = IW'(cur_size - 1'b1);
   assign stack_top  = free_stack[AW'(freed_top - 1'b1)];
   assign alloc_arr  = (freed_top != '0) ? stack_top : AW'(allocated);
   assign last_clear = count == AW'(ARRAYS - 1);

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         CLEAR: begin
            if (last_clear) state_next = IDLE;
         end
         IDLE: begin
            ready = 1'b1;
            if (valid)
               state_next = (action == OP_RESET) ? CLEAR : EXEC;
         end
         EXEC:    state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = CLEAR;
      endcase
   end

   always_comb begin
      res_err  = 1'b0;
      res_data = '0;
      case (op_q)
         OP_ALLOC: begin
            if (freed_top != '0)
               res_data = DATA_WIDTH'(stack_top);
            else if (allocated < CW'(ARRAYS))
               res_data = DATA_WIDTH'(allocated);
            else
               res_err = 1'b1;
         end
         OP_FREE:  res_err = CW'(arr_q) >= allocated;
         OP_READ: begin
            res_err  = SW'(idx_q) >= cur_size;
            res_data = mem[arr_q][idx_q];
         end
         OP_WRITE: res_err = SW'(idx_q) >= cur_size;
         OP_SIZE:  res_data = DATA_WIDTH'(cur_size);
         OP_PUSH:  res_err = cur_size == SW'(ELEMENTS);
         OP_POP: begin
            res_err  = cur_size == '0;
            res_data = mem[arr_q][top_idx];
         end
         default:  res_err = 1'b1;
      endcase
      if (res_err) res_data = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= CLEAR;
         count     <= '0;
         clear_req <= 1'b0;
         allocated <= '0;
         freed_top <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            CLEAR: begin
               sizes[count] <= '0;
               allocated    <= '0;
               freed_top    <= '0;
               count        <= count + 1'b1;
               // done is registered, so arm it one cycle before the
               // final clear cycle of a requested reset.
               if (clear_req && count == AW'(ARRAYS - 2)) begin
                  done     <= 1'b1;
                  error    <= 1'b0;
                  out_data <= '0;
               end
               if (last_clear) clear_req <= 1'b0;
            end
            IDLE: begin
               if (valid) begin
                  op_q  <= action;
                  arr_q <= array;
                  idx_q <= index;
                  din_q <= in_data;
                  if (action == OP_RESET) clear_req <= 1'b1;
               end
            end
            EXEC: begin
               done     <= 1'b1;
               error    <= res_err;
               out_data <= res_data;
               if (!res_err) begin
                  case (op_q)
                     OP_ALLOC: begin
                        sizes[alloc_arr] <= '0;
                        if (freed_top != '0)
                           freed_top <= freed_top - 1'b1;
                        else
                           allocated <= allocated + 1'b1;
                     end
                     OP_FREE: begin
                        // a full stack can only come from double frees;
                        // the extra entry is dropped
                        if (freed_top != CW'(ARRAYS)) begin
                           free_stack[AW'(freed_top)] <= arr_q;
                           freed_top <= freed_top + 1'b1;
                        end
                     end
                     OP_WRITE: mem[arr_q][idx_q] <= din_q;
                     OP_PUSH: begin
                        mem[arr_q][cur_size[IW-1:0]] <= din_q;
                        sizes[arr_q] <= cur_size + 1'b1;
                     end
                     OP_POP:  sizes[arr_q] <= cur_size - 1'b1;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_heap_memory.sv
`timescale 1ns/1ps
// tb_heap_memory: table vectors, hand-written reset sequences and random
// requests checked against a queue/array model of the heap.
module tb_heap_memory;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  action = '0;
   logic [3:0]  array = '0;
   logic [2:0]  index = '0;
   logic [11:0] in_data = '0;
   logic        ready;
   logic        done;
   logic [11:0] out_data;
   logic        error;

   int total = 0;
   int passed = 0;

   heap_memory #(.ARRAYS(16), .ELEMENTS(8), .DATA_WIDTH(12)) dut (
      .clock(clock), .reset(reset), .valid(valid), .action(action),
      .array(array), .index(index), .in_data(in_data), .ready(ready),
      .done(done), .out_data(out_data), .error(error)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   int m_alloc;
   int m_free[$];
   int m_size[16];
   int m_mem[16][8];

   function automatic void model_reset();
      m_alloc = 0;
      m_free.delete();
      for (int i = 0; i < 16; i++) m_size[i] = 0;
   endfunction

   function automatic void model(input int op, input int arr, input int idx,
                                 input int din, output bit e, output int d,
                                 output bit hd);
      e = 0; d = 0; hd = 0;
      case (op)
         2: begin
            hd = 1;
            if (m_free.size() > 0) d = m_free.pop_back();
            else if (m_alloc < 16) begin d = m_alloc; m_alloc++; end
            else e = 1;
            if (!e) m_size[d] = 0;
         end
         3: begin
            if (arr >= m_alloc) e = 1;
            else m_free.push_back(arr);
         end
         4: begin
            hd = 1;
            if (idx >= m_size[arr]) e = 1; else d = m_mem[arr][idx];
         end
         5: begin
            if (idx >= m_size[arr]) e = 1; else m_mem[arr][idx] = din;
         end
         6: begin hd = 1; d = m_size[arr]; end
         7: begin
            if (m_size[arr] == 8) e = 1;
            else begin m_mem[arr][m_size[arr]] = din; m_size[arr]++; end
         end
         8: begin
            hd = 1;
            if (m_size[arr] == 0) e = 1;
            else begin m_size[arr]--; d = m_mem[arr][m_size[arr]]; end
         end
         default: e = 1;
      endcase
      if (e) begin d = 0; hd = 1; end
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else
         passed++;
   endtask

   task automatic req(input int op, input int arr, input int idx,
                      input int din, output logic e, output logic [11:0] d);
      logic [5:0] t;
      int n = 0;
      @(negedge clock);
      while (!ready && n < 50) begin @(negedge clock); n++; end
      if (!ready) begin
         total++;
         $display("FAIL ready_wait: got ready=0, expected 1 within 50 cycles");
      end
      action = 8'(op); array = 4'(arr); index = 3'(idx);
      in_data = 12'(din); valid = 1'b1;
      @(posedge clock); #1 valid = 1'b0;
      t[5:4] = {done, ready};
      @(posedge clock); #1;
      t[3:2] = {done, ready};
      e = error; d = out_data;
      @(posedge clock); #1;
      t[1:0] = {done, ready};
      chk($sformatf("timing op%0d", op), t, 6'b00_10_01);
   endtask

   typedef struct {
      int op; int arr; int idx; int din;
      bit e; int d; bit cd;
   } vec_t;

   function automatic vec_t mk(int op, int arr, int idx, int din,
                               bit e, int d, bit cd);
      vec_t v;
      v.op = op; v.arr = arr; v.idx = idx; v.din = din;
      v.e = e; v.d = d; v.cd = cd;
      return v;
   endfunction

   initial begin
      vec_t vt[$];
      logic e;
      logic [11:0] d;
      bit me, mh;
      int md;

      // Alloc=2 Free=3 Read=4 Write=5 Size=6 Push=7 Pop=8
      vt.push_back(mk(2, 0, 0, 0,   0, 0, 1));
      vt.push_back(mk(2, 0, 0, 0,   0, 1, 1));
      vt.push_back(mk(7, 0, 0, 5,   0, 0, 0));
      vt.push_back(mk(7, 0, 0, 7,   0, 0, 0));
      vt.push_back(mk(6, 0, 0, 0,   0, 2, 1));
      vt.push_back(mk(4, 0, 1, 0,   0, 7, 1));
      vt.push_back(mk(8, 0, 0, 0,   0, 7, 1));
      vt.push_back(mk(6, 0, 0, 0,   0, 1, 1));
      vt.push_back(mk(5, 0, 0, 9,   0, 0, 0));
      vt.push_back(mk(4, 0, 0, 0,   0, 9, 1));
      vt.push_back(mk(3, 0, 0, 0,   0, 0, 0));
      vt.push_back(mk(2, 0, 0, 0,   0, 0, 1));
      vt.push_back(mk(6, 0, 0, 0,   0, 0, 1));
      vt.push_back(mk(3, 5, 0, 0,   1, 0, 1));
      vt.push_back(mk(8'h2A, 0, 0, 0, 1, 0, 1));
      vt.push_back(mk(0, 0, 0, 0,   1, 0, 1));
      vt.push_back(mk(8, 0, 0, 0,   1, 0, 1));
      vt.push_back(mk(6, 0, 0, 0,   0, 0, 1));
      vt.push_back(mk(4, 1, 0, 0,   1, 0, 1));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(7, 1, 0, 100 + i, 0, 0, 0));
      vt.push_back(mk(7, 1, 0, 200, 1, 0, 1));
      vt.push_back(mk(6, 1, 0, 0,   0, 8, 1));
      vt.push_back(mk(4, 1, 7, 0,   0, 107, 1));
      vt.push_back(mk(2, 0, 0, 0,   0, 2, 1));
      vt.push_back(mk(7, 2, 0, 30,  0, 0, 0));
      vt.push_back(mk(7, 2, 0, 31,  0, 0, 0));
      vt.push_back(mk(7, 2, 0, 32,  0, 0, 0));
      vt.push_back(mk(4, 2, 3, 0,   1, 0, 1));
      vt.push_back(mk(4, 2, 7, 0,   1, 0, 1));
      vt.push_back(mk(6, 2, 0, 0,   0, 3, 1));
      vt.push_back(mk(4, 2, 2, 0,   0, 32, 1));

      // ---- power-on reset and clear walk ----
      model_reset();
      @(posedge clock); #1;
      chk("rst_ready", ready, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_out_data", out_data, 0);
      @(negedge clock); reset = 1'b0;
      begin
         bit r15 = 1, r16 = 0, dseen = 0;
         for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            if (done) dseen = 1;
            if (k == 15) r15 = ready;
            if (k == 16) r16 = ready;
         end
         chk("clear_ready_c15", r15, 0);
         chk("clear_ready_c16", r16, 1);
         chk("clear_no_done", dseen, 0);
      end

      // ---- table vectors ----
      foreach (vt[i]) begin
         model(vt[i].op, vt[i].arr, vt[i].idx, vt[i].din, me, md, mh);
         req(vt[i].op, vt[i].arr, vt[i].idx, vt[i].din, e, d);
         chk($sformatf("vec%0d_err", i), e, vt[i].e);
         if (vt[i].cd) chk($sformatf("vec%0d_data", i), d, vt[i].d);
      end

      // ---- reset action ----
      begin
         int dc = 0, dpos = -1;
         bit rlow = 1;
         logic de = 1'b1;
         logic [11:0] dd = 12'hfff;
         @(negedge clock);
         action = 8'd1; valid = 1'b1;
         @(posedge clock); #1 valid = 1'b0;
         for (int j = 0; j <= 16; j++) begin
            if (j > 0) begin @(posedge clock); #1; end
            if (done) begin dc++; dpos = j; de = error; dd = out_data; end
            if (j < 16 && ready) rlow = 0;
         end
         chk("ra_done_count", dc, 1);
         chk("ra_done_cycle", dpos, 15);
         chk("ra_error", de, 0);
         chk("ra_out_data", dd, 0);
         chk("ra_ready_low", rlow, 1);
         chk("ra_ready_back", ready, 1);
         model_reset();
      end

      // ---- allocate every array, then overflow ----
      for (int i = 0; i < 17; i++) begin
         model(2, 0, 0, 0, me, md, mh);
         req(2, 0, 0, 0, e, d);
         chk($sformatf("alloc%0d_err", i), e, (i == 16));
         chk($sformatf("alloc%0d_data", i), d, (i == 16) ? 0 : i);
      end

      // ---- randomized against the model ----
      for (int n = 0; n < 300; n++) begin
         int r, op, arr, idx, din;
         r   = $urandom_range(0, 99);
         arr = $urandom_range(0, 15);
         idx = $urandom_range(0, 7);
         din = $urandom_range(0, 4095);
         if (r < 10) op = 2;
         else if (r < 20) op = (m_free.size() < 16) ? 3 : 6;
         else if (r < 35) op = 4;
         else if (r < 50) op = 5;
         else if (r < 60) op = 6;
         else if (r < 78) op = 7;
         else if (r < 95) op = 8;
         else op = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 255);
         model(op, arr, idx, din, me, md, mh);
         req(op, arr, idx, din, e, d);
         chk($sformatf("rnd%0d_op%0d_err", n, op), e, me);
         if (mh) chk($sformatf("rnd%0d_op%0d_data", n, op), d, md);
      end

      // ---- hardware reset during EXEC ----
      begin
         bit dseen = 0, r15 = 1, r16 = 0;
         int n = 0;
         @(negedge clock);
         while (!ready && n < 50) begin @(negedge clock); n++; end
         action = 8'd6; array = 4'd0; valid = 1'b1;
         @(posedge clock); #1 valid = 1'b0;
         @(negedge clock); reset = 1'b1;
         @(posedge clock); #1;
         if (done) dseen = 1;
         @(negedge clock); reset = 1'b0;
         for (int k = 1; k <= 16; k++) begin
            @(posedge clock); #1;
            if (done) dseen = 1;
            if (k == 15) r15 = ready;
            if (k == 16) r16 = ready;
         end
         chk("hwrst_done_suppressed", dseen, 0);
         chk("hwrst_ready_c15", r15, 0);
         chk("hwrst_ready_c16", r16, 1);
         model_reset();
         req(2, 0, 0, 0, e, d);
         chk("hwrst_alloc_err", e, 0);
         chk("hwrst_alloc_data", d, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
